alexander_pd_vote: RTL and testbench
====================================

Name: alexander_pd_vote

Overview:
- Parametrised successor to the CDR bang-bang (Alexander) phase detector.
- Owns its own sample-phase counter with a runtime-programmable bit period.
- Takes a data sample and an edge sample per bit, produces per-bit transition/early/late decisions and the recovered data bit.
- Accumulates decisions into a thresholded vote, and accepts advance/retard steps from the downstream loop filter, closing the Zigbee receive CDR loop.

Parameters:
- CNT_W, 6, width of phase counter and i_period.
- VOTE_N, 8, bit periods per vote window (>=1).
- VOTE_TH, 3, |accumulator| needed to assert a vote (1..VOTE_N).
- ACC_W, 5, signed accumulator width; must hold ±VOTE_N.

Ports:
- i_clk  in  1  work clock (50 MHz), all logic on posedge.
- i_rst  in  1  reset, synchronous, active-low.
- i_en  in  1  enable; low = idle/flush.
- i_dir  in  1  incoming chip stream, already synchronised.
- i_period  in  CNT_W  clocks per bit; values <4 treated as 4.
- i_step  in  2  00 none, 01 advance, 10 retard, 11 = none.
- o_data  out  1  recovered bit.
- o_dec_valid  out  1  one-cycle pulse: o_data/o_T/o_late/o_early valid.
- o_T  out  1  transition detected between consecutive bits.
- o_late  out  1  T and edge sample already equals new bit.
- o_early  out  1  T and edge sample still equals old bit.
- o_vote_valid  out  1  one-cycle pulse at end of vote window.
- o_vote_up  out  1  clock late: request advance.
- o_vote_dn  out  1  clock early: request retard.

Behaviour:
- Reset (i_rst=0 at posedge): cnt=0, r_per=max(i_period,4), r_a=r_b=0, prime=0, acc=0, win=0. All outputs 0.
- i_en=0: same flush as reset except r_per reloads. Outputs hold 0.
- Phase counter, i_en=1:
  - Normal: cnt <= (cnt+1) mod r_per.
  - Advance (i_step=01): cnt <= (cnt+2) mod r_per; at cnt=r_per-2 it lands on 0; at cnt=r_per-1 it lands on 1, skipping the data sample for that cycle.
  - Retard (i_step=10): cnt holds.
  - i_step is evaluated every cycle.
- r_per reloads from i_period only on the cycle cnt wraps to 0, so a period change never truncates a bit.
- Edge sample: on cycle with cnt==r_per>>1, r_b <= i_dir.
- Data sample: on cycle with cnt==0 ("strobe"):
  - r_a <= i_dir (old r_a becomes the previous bit).
  - Registered next cycle (latency 1): o_data=i_dir, o_T=r_a^i_dir, o_late=o_T&(r_b==i_dir), o_early=o_T&(r_b==r_a), o_dec_valid=prime.
  - prime <= 1, so the first strobe after reset/enable yields no valid decision.
- Outputs o_T/o_late/o_early/o_data hold between strobes. o_dec_valid is 1 for exactly one cycle. o_late and o_early are never both 1.
- Vote accumulator, on each valid decision:
  - acc += +1 if late, -1 if early, 0 otherwise.
  - win++. When win reaches VOTE_N-1 and a decision arrives, use the final acc' (including this decision).
  - Next cycle: o_vote_valid=1, o_vote_up=(acc'>=VOTE_TH), o_vote_dn=(acc'<=-VOTE_TH), acc=0, win=0.
  - Vote outputs are pulses, 0 otherwise.
- Advance during a strobe-skipping jump: no decision that bit. The accumulator is unaffected.
- Reset or i_en low mid-window discards the partial window and emits no vote.

Test Plan:
- Reset: hold i_rst=0 3 cycles with i_dir toggling -> all outputs 0, no o_dec_valid.
- Aligned data: i_period=8, i_dir=1010… with transitions at cnt=4, i_step=00 -> o_T=1 every bit. Edge sample catches the new value in the 4 cycles after the transition -> o_late=1, o_vote_up pulses every 8 bits.
- Early clock: shift transitions to cnt=6 (data constant 00111100…) -> o_early on each transition; with ≥3 transitions per 8 bits, o_vote_dn=1.
- No transitions: i_dir=0 constant for 20 bits -> o_dec_valid each bit, o_T=0, acc=0, vote_valid with up=dn=0.
- Steps: pulse i_step=01 at cnt=6, period 8 -> next strobe one cycle earlier (cnt 6→0). i_step=10 for 3 cycles -> strobe spacing 11 cycles. i_period=3 -> spacing 4.
- Mid-window flush: i_en low after 5 decisions, then high -> first strobe gives no valid decision; the next vote arrives only after 8 fresh decisions.

Source files
------------

// File: rtl/alexander_pd_vote.sv
// Bang-bang (Alexander) phase detector with its own sample-phase counter and a
// windowed early/late vote that feeds the receive CDR loop filter.
module alexander_pd_vote #(
    parameter int CNT_W   = 6,
    parameter int VOTE_N  = 8,
    parameter int VOTE_TH = 3,
    parameter int ACC_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic [CNT_W-1:0] i_period,
    input  logic [1:0]       i_step,
    output logic             o_data,
    output logic             o_dec_valid,
    output logic             o_T,
    output logic             o_late,
    output logic             o_early,
    output logic             o_vote_valid,
    output logic             o_vote_up,
    output logic             o_vote_dn
);

    localparam int WIN_W = (VOTE_N > 1) ? $clog2(VOTE_N) : 1;
    localparam logic [CNT_W-1:0]        PER_MIN = CNT_W'(4);
    localparam logic [WIN_W-1:0]        WIN_END = WIN_W'(VOTE_N - 1);
    localparam logic signed [ACC_W-1:0] TH_P    = ACC_W'(VOTE_TH);
    localparam logic signed [ACC_W-1:0] TH_N    = -TH_P;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        per_q;
    logic                    a_q, b_q, prime_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [WIN_W-1:0]        win_q;
    logic                    data_q, dec_valid_q, t_q, late_q, early_q;
    logic                    vote_valid_q, vote_up_q, vote_dn_q;

    logic [CNT_W-1:0] per_eff;
    logic [CNT_W:0]   cnt_p1, cnt_p2, cnt_p2_wr, per_ext;
    logic             wrap, strobe, edge_smp, trans, win_last;

    assign per_eff   = (i_period < PER_MIN) ? PER_MIN : i_period;
    assign per_ext   = {1'b0, per_q};
    assign cnt_p1    = {1'b0, cnt_q} + 1'b1;
    assign cnt_p2    = {1'b0, cnt_q} + 2'd2;
    assign cnt_p2_wr = cnt_p2 - per_ext;

    // Advance jumps two phases; from r_per-1 it lands on 1 and skips that strobe.
    always_comb begin
        cnt_d = cnt_q;
        case (i_step)
            2'b01:   cnt_d = (cnt_p2 >= per_ext) ? cnt_p2_wr[CNT_W-1:0] : cnt_p2[CNT_W-1:0];
            2'b10:   cnt_d = cnt_q;
            default: cnt_d = (cnt_p1 >= per_ext) ? '0 : cnt_p1[CNT_W-1:0];
        endcase
    end

    // Period only changes at a bit boundary so a running bit is never truncated.
    assign wrap     = (cnt_d == '0) && (cnt_q != '0);
    assign strobe   = (cnt_q == '0);
    assign edge_smp = (cnt_q == (per_q >> 1));
    assign trans    = a_q ^ i_dir;
    assign win_last = (win_q == WIN_END);

    always_comb begin
        acc_d = acc_q;
        if (late_q) begin
            acc_d = acc_q + ACC_W'(1);
        end else if (early_q) begin
            acc_d = acc_q - ACC_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst || !i_en) begin
            cnt_q        <= '0;
            per_q        <= per_eff;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            prime_q      <= 1'b0;
            acc_q        <= '0;
            win_q        <= '0;
            data_q       <= 1'b0;
            dec_valid_q  <= 1'b0;
            t_q          <= 1'b0;
            late_q       <= 1'b0;
            early_q      <= 1'b0;
            vote_valid_q <= 1'b0;
            vote_up_q    <= 1'b0;
            vote_dn_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (wrap) begin
                per_q <= per_eff;
            end
            if (edge_smp) begin
                b_q <= i_dir;
            end

            dec_valid_q <= 1'b0;
            if (strobe) begin
                a_q         <= i_dir;
                prime_q     <= 1'b1;
                data_q      <= i_dir;
                t_q         <= trans;
                late_q      <= trans & (b_q == i_dir);
                early_q     <= trans & (b_q == a_q);
                dec_valid_q <= prime_q;
            end

            vote_valid_q <= 1'b0;
            vote_up_q    <= 1'b0;
            vote_dn_q    <= 1'b0;
            if (dec_valid_q) begin
                if (win_last) begin
                    vote_valid_q <= 1'b1;
                    vote_up_q    <= (acc_d >= TH_P);
                    vote_dn_q    <= (acc_d <= TH_N);
                    acc_q        <= '0;
                    win_q        <= '0;
                end else begin
                    acc_q <= acc_d;
                    win_q <= win_q + WIN_W'(1);
                end
            end
        end
    end

    assign o_data       = data_q;
    assign o_dec_valid  = dec_valid_q;
    assign o_T          = t_q;
    assign o_late       = late_q;
    assign o_early      = early_q;
    assign o_vote_valid = vote_valid_q;
    assign o_vote_up    = vote_up_q;
    assign o_vote_dn    = vote_dn_q;

endmodule

// File: tb/tb_alexander_pd_vote.sv
// Directed bench for alexander_pd_vote: decisions, votes, phase steps and flush.
module tb_alexander_pd_vote;

    localparam int CNT_W = 6;
    localparam int PAT_ALT = 0, PAT_EARLY = 1, PAT_ZERO = 2, PAT_TH = 3;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_en = 1'b0;
    logic             i_dir = 1'b0;
    logic [CNT_W-1:0] i_period = 6'd8;
    logic [1:0]       i_step = 2'b00;
    logic o_data, o_dec_valid, o_T, o_late, o_early, o_vote_valid, o_vote_up, o_vote_dn;

    alexander_pd_vote #(.CNT_W(CNT_W), .VOTE_N(8), .VOTE_TH(3), .ACC_W(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_dir(i_dir),
        .i_period(i_period), .i_step(i_step),
        .o_data(o_data), .o_dec_valid(o_dec_valid), .o_T(o_T), .o_late(o_late),
        .o_early(o_early), .o_vote_valid(o_vote_valid), .o_vote_up(o_vote_up),
        .o_vote_dn(o_vote_dn)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int kcyc;
    int n_dec, n_t, n_late, n_early, n_both, n_vv, n_up, n_dn, d_bad, last_vote;
    int dec_q[$];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic pat_bit(input int pat, input int n);
        case (pat)
            PAT_ALT:   return (n % 2) == 0;
            PAT_EARLY: return (((n + 1) / 2) % 2) == 1;
            PAT_TH:    return !(n == 0 || n == 2 || n == 9);
            default:   return 1'b0;
        endcase
    endfunction

    task automatic clear_counts();
        n_dec = 0; n_t = 0; n_late = 0; n_early = 0; n_both = 0;
        n_vv = 0; n_up = 0; n_dn = 0; d_bad = 0; last_vote = -1;
        dec_q.delete();
    endtask

    task automatic cyc(input logic en, input logic dir, input logic [1:0] step);
        @(negedge i_clk);
        i_en = en; i_dir = dir; i_step = step;
        @(posedge i_clk);
        #1;
        if (o_dec_valid) begin
            n_dec++;
            dec_q.push_back(kcyc);
            if (o_T) n_t++;
            if (o_late) n_late++;
            if (o_early) n_early++;
        end
        if (o_late && o_early) n_both++;
        if (o_vote_valid) begin
            n_vv++;
            last_vote = kcyc;
        end
        if (o_vote_up) n_up++;
        if (o_vote_dn) n_dn++;
    endtask

    task automatic flush();
        kcyc = -1;
        cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b00);
    endtask

    // Period 8, counter starts at 0 on the first enabled edge; i_dir switches to
    // the next bit value from phase tp onward.
    task automatic drive_pat(input int k0, input int k1, input int tp, input int pat);
        for (int k = k0; k < k1; k++) begin
            int n, c;
            n = k / 8;
            c = k % 8;
            kcyc = k;
            cyc(1'b1, (c < tp) ? pat_bit(pat, n) : pat_bit(pat, n + 1), 2'b00);
            if (c == 0 && n >= 1) begin
                if (!o_dec_valid || o_data !== pat_bit(pat, n)) d_bad++;
            end else if (o_dec_valid) begin
                d_bad++;
            end
        end
    endtask

    task automatic test_reset();
        i_period = 6'd8;
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, logic'(i % 2), 2'b00);
            checks++;
            if ({o_data, o_dec_valid, o_T, o_late, o_early, o_vote_valid, o_vote_up, o_vote_dn} !== 8'h00) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d got=%b exp=00000000", i,
                         {o_data, o_dec_valid, o_T, o_late, o_early, o_vote_valid, o_vote_up, o_vote_dn});
            end
        end
        i_rst = 1'b1;
    endtask

    task automatic test_aligned();
        clear_counts(); flush();
        drive_pat(0, 138, 4, PAT_ALT);
        checks++; if (n_dec !== 17) begin failures++; $display("FAIL aligned_dec got=%0d exp=17", n_dec); end
        checks++; if (n_t !== 17) begin failures++; $display("FAIL aligned_T got=%0d exp=17", n_t); end
        checks++; if (n_late !== 17) begin failures++; $display("FAIL aligned_late got=%0d exp=17", n_late); end
        checks++; if (n_early !== 0) begin failures++; $display("FAIL aligned_early got=%0d exp=0", n_early); end
        checks++; if (n_vv !== 2) begin failures++; $display("FAIL aligned_votes got=%0d exp=2", n_vv); end
        checks++; if (n_up !== 2 || n_dn !== 0) begin failures++; $display("FAIL aligned_up_dn got=%0d/%0d exp=2/0", n_up, n_dn); end
        checks++; if (last_vote !== 129) begin failures++; $display("FAIL aligned_vote_cycle got=%0d exp=129", last_vote); end
        checks++; if (d_bad !== 0) begin failures++; $display("FAIL aligned_data bad=%0d exp=0", d_bad); end
        checks++; if (o_T !== 1'b1 || o_late !== 1'b1 || o_dec_valid !== 1'b0) begin
            failures++; $display("FAIL aligned_hold got T=%b late=%b dv=%b exp 1 1 0", o_T, o_late, o_dec_valid);
        end
        checks++; if (n_both !== 0) begin failures++; $display("FAIL aligned_both got=%0d exp=0", n_both); end
    endtask

    task automatic test_early();
        clear_counts(); flush();
        drive_pat(0, 138, 6, PAT_EARLY);
        checks++; if (n_dec !== 17) begin failures++; $display("FAIL early_dec got=%0d exp=17", n_dec); end
        checks++; if (n_early !== 9) begin failures++; $display("FAIL early_early got=%0d exp=9", n_early); end
        checks++; if (n_late !== 0) begin failures++; $display("FAIL early_late got=%0d exp=0", n_late); end
        checks++; if (n_vv !== 2) begin failures++; $display("FAIL early_votes got=%0d exp=2", n_vv); end
        checks++; if (n_dn !== 2 || n_up !== 0) begin failures++; $display("FAIL early_dn_up got=%0d/%0d exp=2/0", n_dn, n_up); end
        checks++; if (d_bad !== 0) begin failures++; $display("FAIL early_data bad=%0d exp=0", d_bad); end
    endtask

    task automatic test_no_trans();
        clear_counts(); flush();
        drive_pat(0, 162, 4, PAT_ZERO);
        checks++; if (n_dec !== 20) begin failures++; $display("FAIL notrans_dec got=%0d exp=20", n_dec); end
        checks++; if (n_t !== 0) begin failures++; $display("FAIL notrans_T got=%0d exp=0", n_t); end
        checks++; if (n_vv !== 2) begin failures++; $display("FAIL notrans_votes got=%0d exp=2", n_vv); end
        checks++; if (n_up !== 0 || n_dn !== 0) begin failures++; $display("FAIL notrans_up_dn got=%0d/%0d exp=0/0", n_up, n_dn); end
    endtask

    task automatic test_threshold();
        clear_counts(); flush();
        drive_pat(0, 130, 4, PAT_TH);
        checks++; if (n_late !== 5) begin failures++; $display("FAIL thresh_late got=%0d exp=5", n_late); end
        checks++; if (n_vv !== 2) begin failures++; $display("FAIL thresh_votes got=%0d exp=2", n_vv); end
        checks++; if (n_up !== 1 || n_dn !== 0) begin failures++; $display("FAIL thresh_up_dn got=%0d/%0d exp=1/0", n_up, n_dn); end
        checks++; if (d_bad !== 0) begin failures++; $display("FAIL thresh_data bad=%0d exp=0", d_bad); end
    endtask

    task automatic test_steps();
        int exp_s[8] = '{8, 15, 23, 34, 42, 46, 50, 57};
        logic [1:0] st;
        i_period = 6'd8;
        clear_counts(); flush();
        for (int k = 0; k < 59; k++) begin
            st = 2'b00;
            if (k == 14 || k == 53) st = 2'b01;
            if (k >= 25 && k <= 27) st = 2'b10;
            if (k == 20) st = 2'b11;
            if (k == 34) i_period = 6'd3;
            kcyc = k;
            cyc(1'b1, 1'b0, st);
        end
        checks++;
        if (dec_q.size() !== 8) begin
            failures++; $display("FAIL steps_count got=%0d exp=8", dec_q.size());
        end
        for (int i = 0; i < 8 && i < dec_q.size(); i++) begin
            checks++;
            if (dec_q[i] !== exp_s[i]) begin
                failures++; $display("FAIL steps_strobe%0d got=%0d exp=%0d", i, dec_q[i], exp_s[i]);
            end
        end
        i_period = 6'd8;
    endtask

    task automatic test_flush();
        clear_counts(); flush();
        drive_pat(0, 42, 4, PAT_ALT);
        checks++; if (n_dec !== 5 || n_vv !== 0) begin failures++; $display("FAIL flush_pre got dec=%0d votes=%0d exp 5 0", n_dec, n_vv); end
        kcyc = -1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b00);
        checks++;
        if ({o_data, o_dec_valid, o_T, o_late, o_early, o_vote_valid, o_vote_up, o_vote_dn} !== 8'h00) begin
            failures++; $display("FAIL flush_outputs got=%b exp=00000000",
                {o_data, o_dec_valid, o_T, o_late, o_early, o_vote_valid, o_vote_up, o_vote_dn});
        end
        clear_counts();
        drive_pat(0, 64, 4, PAT_ALT);
        checks++; if (n_dec !== 7 || n_vv !== 0) begin failures++; $display("FAIL flush_mid got dec=%0d votes=%0d exp 7 0", n_dec, n_vv); end
        drive_pat(64, 66, 4, PAT_ALT);
        checks++; if (n_dec !== 8 || n_vv !== 1 || n_up !== 1) begin
            failures++; $display("FAIL flush_vote got dec=%0d votes=%0d up=%0d exp 8 1 1", n_dec, n_vv, n_up);
        end
        checks++; if (last_vote !== 65) begin failures++; $display("FAIL flush_vote_cycle got=%0d exp=65", last_vote); end
        checks++; if (d_bad !== 0) begin failures++; $display("FAIL flush_data bad=%0d exp=0", d_bad); end
    endtask

    initial begin
        kcyc = -1;
        clear_counts();
        test_reset();
        test_aligned();
        test_early();
        test_no_trans();
        test_threshold();
        test_steps();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
